// File: rtl/mem_axi_pkg.sv
// Shared definitions for the AXI memory slave mem_axi_gen2.
// Contents: burst-type encodings, response encodings, write/read FSM
// state types and a constant-evaluable clog2 helper.
package mem_axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  // Smallest r with 2**r >= value; 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_axi_addr_gen.sv
// Next-beat address generator for one AXI channel.
// Ports:
//   addr      - byte address of the current beat
//   len       - burst length minus one (AxLEN)
//   burst     - burst type (AxBURST)
//   next_addr - byte address of the following beat
// FIXED keeps the address, INCR and the reserved type 11 step by one word,
// WRAP wraps inside the (len+1)-word aligned window when len is 1/3/7/15
// and otherwise behaves as INCR.
module mem_axi_addr_gen
  import mem_axi_pkg::*;
#(
  parameter int AXI_WIDTH_AD = 32,
  parameter int AXI_WIDTH_DA = 32
) (
  input  logic [AXI_WIDTH_AD-1:0] addr,
  input  logic [7:0]              len,
  input  logic [1:0]              burst,
  output logic [AXI_WIDTH_AD-1:0] next_addr
);

  localparam int LO = clog2(AXI_WIDTH_DA / 8);
  localparam logic [AXI_WIDTH_AD-1:0] STEP = AXI_WIDTH_AD'(AXI_WIDTH_DA / 8);

  logic [AXI_WIDTH_AD-1:0] mask;
  logic [AXI_WIDTH_AD-1:0] incr_addr;
  logic                    wrap_ok;

  always_comb begin
    // Window mask covers the word-index bits that rotate inside the wrap
    // window; everything outside it (including sub-word bits) is kept.
    mask      = {{(AXI_WIDTH_AD-8){1'b0}}, len} << LO;
    incr_addr = addr + STEP;
    wrap_ok   = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    next_addr = incr_addr;
    if (burst == BURST_FIXED) begin
      next_addr = addr;
    end else if ((burst == BURST_WRAP) && wrap_ok) begin
      next_addr = (addr & ~mask) | (incr_addr & mask);
    end
  end

endmodule

// File: rtl/mem_axi_gen2.sv
// AXI3-style single-port-per-channel memory slave.
// Ports: ACLK/ARESETn (async active-low reset); AW channel (AWID, AWADDR,
// AWLEN, AWBURST, AWVALID, AWREADY); W channel (WDATA, WSTRB, WLAST,
// WVALID, WREADY); B channel (BID, BRESP, BVALID, BREADY); AR channel
// (ARID, ARADDR, ARLEN, ARBURST, ARVALID, ARREADY); R channel (RID, RDATA,
// RRESP, RLAST, RVALID, RREADY).
// Optional macro MEM_AXI_SLVERR_EN: beats addressed at or beyond
// P_SIZE_IN_BYTES return SLVERR (writes suppressed, reads return zero).
// Without it, addresses alias modulo the memory size and responses are OKAY.
module mem_axi_gen2
  import mem_axi_pkg::*;
#(
  parameter int AXI_WIDTH_SID   = 8,
  parameter int AXI_WIDTH_AD    = 32,
  parameter int AXI_WIDTH_DA    = 32,
  parameter int P_SIZE_IN_BYTES = 4096
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic [AXI_WIDTH_SID-1:0]  AWID,
  input  logic [AXI_WIDTH_AD-1:0]   AWADDR,
  input  logic [7:0]                AWLEN,
  input  logic [1:0]                AWBURST,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [AXI_WIDTH_DA-1:0]   WDATA,
  input  logic [AXI_WIDTH_DA/8-1:0] WSTRB,
  input  logic                      WLAST,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [AXI_WIDTH_SID-1:0]  BID,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  input  logic [AXI_WIDTH_SID-1:0]  ARID,
  input  logic [AXI_WIDTH_AD-1:0]   ARADDR,
  input  logic [7:0]                ARLEN,
  input  logic [1:0]                ARBURST,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  output logic [AXI_WIDTH_SID-1:0]  RID,
  output logic [AXI_WIDTH_DA-1:0]   RDATA,
  output logic [1:0]                RRESP,
  output logic                      RLAST,
  output logic                      RVALID,
  input  logic                      RREADY
);

  localparam int STRB_W = AXI_WIDTH_DA / 8;
  localparam int LO     = clog2(STRB_W);
  localparam int HI     = clog2(P_SIZE_IN_BYTES) - 1;
  localparam int IDX_W  = HI - LO + 1;
  localparam int WORDS  = P_SIZE_IN_BYTES / STRB_W;

  logic [AXI_WIDTH_DA-1:0] mem [WORDS];

  // Holds both READY outputs low until the first clock edge after reset.
  logic ready_en;

  w_state_e w_state, w_next;
  r_state_e r_state, r_next;

  logic [AXI_WIDTH_AD-1:0] w_addr, w_next_addr;
  logic [7:0]              w_len, w_cnt;
  logic [1:0]              w_burst;
  logic                    w_err, w_beat_err;
  logic [IDX_W-1:0]        w_idx;

  logic [AXI_WIDTH_AD-1:0] r_addr, r_next_addr, r_src_addr;
  logic [7:0]              r_len, r_cnt, r_src_len;
  logic [1:0]              r_burst, r_src_burst;
  logic                    r_beat_err;
  logic [IDX_W-1:0]        r_idx;

  logic aw_hs, w_hs, ar_hs, r_hs;
  logic unused_bits;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign ar_hs = ARVALID && ARREADY;
  assign r_hs  = RVALID && RREADY;

  // While idle the read side looks straight at the AR request so the first
  // beat can be fetched on the handshake edge; afterwards it follows the
  // latched burst. r_addr always points at the next beat to fetch.
  assign r_src_addr  = (r_state == R_IDLE) ? ARADDR  : r_addr;
  assign r_src_len   = (r_state == R_IDLE) ? ARLEN   : r_len;
  assign r_src_burst = (r_state == R_IDLE) ? ARBURST : r_burst;

  assign w_idx = w_addr[HI:LO];
  assign r_idx = r_src_addr[HI:LO];
  assign unused_bits = ^{w_addr, r_src_addr, WLAST};

`ifdef MEM_AXI_SLVERR_EN
  localparam logic [AXI_WIDTH_AD:0] SIZE_EXT = (AXI_WIDTH_AD+1)'(P_SIZE_IN_BYTES);
  assign w_beat_err = ({1'b0, w_addr} >= SIZE_EXT);
  assign r_beat_err = ({1'b0, r_src_addr} >= SIZE_EXT);
`else
  assign w_beat_err = 1'b0;
  assign r_beat_err = 1'b0;
`endif

  mem_axi_addr_gen #(.AXI_WIDTH_AD(AXI_WIDTH_AD), .AXI_WIDTH_DA(AXI_WIDTH_DA)) u_waddr (
    .addr(w_addr), .len(w_len), .burst(w_burst), .next_addr(w_next_addr)
  );

  mem_axi_addr_gen #(.AXI_WIDTH_AD(AXI_WIDTH_AD), .AXI_WIDTH_DA(AXI_WIDTH_DA)) u_raddr (
    .addr(r_src_addr), .len(r_src_len), .burst(r_src_burst), .next_addr(r_next_addr)
  );

  // State registers
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state  <= W_IDLE;
      r_state  <= R_IDLE;
      ready_en <= 1'b0;
    end else begin
      w_state  <= w_next;
      r_state  <= r_next;
      ready_en <= 1'b1;
    end
  end

  // Write FSM next state and handshake outputs
  always_comb begin
    w_next  = w_state;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    case (w_state)
      W_IDLE: begin
        AWREADY = ready_en;
        if (AWVALID && ready_en) w_next = W_DATA;
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID && (w_cnt == w_len)) w_next = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Read FSM next state and AR handshake output
  always_comb begin
    r_next  = r_state;
    ARREADY = 1'b0;
    case (r_state)
      R_IDLE: begin
        ARREADY = ready_en;
        if (ARVALID && ready_en) r_next = R_DATA;
      end
      R_DATA: begin
        if (r_hs && RLAST) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Write burst tracking
  always_ff @(posedge ACLK) begin
    if (aw_hs) begin
      w_addr  <= AWADDR;
      w_len   <= AWLEN;
      w_burst <= AWBURST;
      w_cnt   <= 8'd0;
      w_err   <= 1'b0;
    end else if (w_hs) begin
      w_addr <= w_next_addr;
      w_cnt  <= w_cnt + 8'd1;
      w_err  <= w_err | w_beat_err;
    end
  end

  // Memory array: byte-enabled writes, contents untouched by reset
  always_ff @(posedge ACLK) begin
    if (w_hs && !w_beat_err) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (WSTRB[b]) mem[w_idx][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  // Write response
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      BID   <= '0;
      BRESP <= RESP_OKAY;
    end else begin
      if (aw_hs) BID <= AWID;
      if (w_hs && (w_cnt == w_len)) BRESP <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // Read burst tracking
  always_ff @(posedge ACLK) begin
    if (ar_hs) begin
      r_addr  <= r_next_addr;
      r_len   <= ARLEN;
      r_burst <= ARBURST;
      r_cnt   <= 8'd0;
    end else if (r_hs && !RLAST) begin
      r_addr <= r_next_addr;
      r_cnt  <= r_cnt + 8'd1;
    end
  end

  // Read data channel: a new beat is loaded on the AR handshake and on every
  // accepted non-last beat, so outputs stay frozen while RREADY is low.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      RVALID <= 1'b0;
      RLAST  <= 1'b0;
      RID    <= '0;
      RDATA  <= '0;
      RRESP  <= RESP_OKAY;
    end else begin
      if (ar_hs || (r_hs && !RLAST)) begin
        RVALID <= 1'b1;
        RDATA  <= r_beat_err ? '0 : mem[r_idx];
        RRESP  <= r_beat_err ? RESP_SLVERR : RESP_OKAY;
      end
      if (ar_hs) begin
        RID   <= ARID;
        RLAST <= (ARLEN == 8'd0);
      end else if (r_hs && !RLAST) begin
        RLAST <= ((r_cnt + 8'd1) == r_len);
      end else if (r_hs) begin
        RVALID <= 1'b0;
        RLAST  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mem_axi_gen2.md
MEM_AXI_GEN2 -- requirements
Module: mem_axi_gen2
Interface
REQ-001 SHALL have parameter AXI_WIDTH_SID, default 8, full ID width ({channel-ID, ID}).
REQ-002 SHALL have parameter AXI_WIDTH_AD, default 32, address width.
REQ-003 SHALL have parameter AXI_WIDTH_DA, default 32, data width; legal values are 32, 64 and 128.
REQ-004 SHALL have parameter P_SIZE_IN_BYTES, default 4096, memory size; it is a power of two.
REQ-005 SHALL have port ACLK  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port ARESETn  in  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port AWID  in  AXI_WIDTH_SID  write ID.
REQ-008 SHALL have port AWADDR  in  AXI_WIDTH_AD  write start byte address.
REQ-009 SHALL have port AWLEN  in  8  beats minus one.
REQ-010 SHALL have port AWBURST  in  2  burst type.
REQ-011 SHALL have port AWVALID  in  1  AW valid.
REQ-012 SHALL have port AWREADY  out  1  AW ready.
REQ-013 SHALL have port WDATA  in  AXI_WIDTH_DA  write data.
REQ-014 SHALL have port WSTRB  in  AXI_WIDTH_DA/8  byte strobes.
REQ-015 SHALL have port WLAST  in  1  last write beat.
REQ-016 SHALL have port WVALID  in  1  W valid.
REQ-017 SHALL have port WREADY  out  1  W ready.
REQ-018 SHALL have port BID  out  AXI_WIDTH_SID  response ID.
REQ-019 SHALL have port BRESP  out  2  write response.
REQ-020 SHALL have port BVALID  out  1  B valid.
REQ-021 SHALL have port BREADY  in  1  B ready.
REQ-022 SHALL have port ARID  in  AXI_WIDTH_SID  read ID.
REQ-023 SHALL have port ARADDR  in  AXI_WIDTH_AD  read start byte address.
REQ-024 SHALL have port ARLEN  in  8  beats minus one.
REQ-025 SHALL have port ARBURST  in  2  burst type.
REQ-026 SHALL have port ARVALID  in  1  AR valid.
REQ-027 SHALL have port ARREADY  out  1  AR ready.
REQ-028 SHALL have port RID  out  AXI_WIDTH_SID  read ID.
REQ-029 SHALL have port RDATA  out  AXI_WIDTH_DA  read data.
REQ-030 SHALL have port RRESP  out  2  read response.
REQ-031 SHALL have port RLAST  out  1  last read beat.
REQ-032 SHALL have port RVALID  out  1  R valid.
REQ-033 SHALL have port RREADY  in  1  R ready.
Function
REQ-034 SHALL hold P_SIZE_IN_BYTES/(AXI_WIDTH_DA/8) words; word index = ADDR bits between log2(DA/8) and log2(P_SIZE_IN_BYTES)-1; beats are always full width; address bits below the word index are ignored.
REQ-035 SHALL run the write FSM W_IDLE->W_DATA->W_RESP->W_IDLE:
- W_IDLE: AWREADY=1; on handshake, latch ID/ADDR/LEN/BURST.
- W_DATA: WREADY=1; each handshake writes the bytes enabled by WSTRB.
- Leaves W_DATA on handshake of beat AWLEN; WLAST is ignored for termination.
- W_RESP: BVALID=1, BID=latched AWID, stable until BREADY.
REQ-036 SHALL run the read FSM R_IDLE->R_DATA->R_IDLE:
- R_IDLE: ARREADY=1.
- First RVALID exactly one cycle after the AR handshake.
- RID/RDATA/RLAST/RRESP held stable while RVALID=1 and RREADY=0.
- RLAST=1 on beat ARLEN.
- Returns to R_IDLE after the last handshake.
- Back-to-back beats at one per cycle when RREADY=1.
REQ-037 SHALL advance the beat address as follows:
- FIXED (00): constant.
- INCR (01): +1 word.
- WRAP (10): wrap within the (LEN+1)-word aligned window.
- 11: treated as INCR.
- WRAP with LEN not in {1,3,7,15}: treated as INCR.
REQ-038 SHALL operate the read and write channels concurrently; a read of a word written in the same cycle returns the old data; a write completing in W_RESP does not block reads.
Reset
REQ-039 SHALL on ARESETn=0 immediately:
- Drive AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST to 0.
- Drive BID, BRESP, RID, RDATA, RRESP to 0.
- Put both FSMs in IDLE, abandoning any burst mid-flight.
- Leave memory contents unchanged.
- Enter IDLE READY=1 on the first ACLK edge after release.
Configuration
REQ-040 SHALL, with macro MEM_AXI_SLVERR_EN defined, treat any beat whose address is at or above P_SIZE_IN_BYTES as an error:
- Write beat: suppressed; BRESP=2'b10 if any beat of the burst erred.
- Read beat: RDATA=0, RRESP=2'b10.
- Without the macro: addresses wrap modulo P_SIZE_IN_BYTES and responses are always 2'b00.
Structure
REQ-041 SHALL place burst and response encodings, FSM state encodings and a clog2 function in shared package mem_axi_pkg, and implement next-address logic in sub-module mem_axi_addr_gen, instantiated once per channel.
Verification
REQ-042 SHALL cover: INCR write, AWADDR=0x10, AWLEN=3, data 1..4, WSTRB=all-ones -> BRESP=00 after 4th beat; INCR read of 0x10 -> RDATA 1,2,3,4 with RLAST on 4th.
REQ-043 SHALL cover: WRAP read, DA=32, ARADDR=0x18, ARLEN=3 -> words read in order 0x18,0x1C,0x10,0x14.
REQ-044 SHALL cover: RREADY held 0 for 5 cycles mid-burst -> RDATA/RLAST unchanged; no beat lost or duplicated.
REQ-045 SHALL cover: write to 0x20 with WSTRB=4'b0101, data 0xAABBCCDD over 0x11223344 -> readback 0x11BB33DD.
REQ-046 SHALL cover: ARESETn pulsed low during beat 2 of an 8-beat read -> RVALID=0 at once; a new read after release returns correct data; with MEM_AXI_SLVERR_EN, read at 0x1000 (size 4096) -> RRESP=10, RDATA=0.
